transmitter_spi: RTL
====================

Name: transmitter_spi

Overview:
- SPI master for the SPI link. Sits directly upstream of the slave receiver and feeds it.
- Generates SCK, SS and MOSI from a parallel word, and samples MISO into a parallel result.
- Full duplex, one frame per start request. Supports all four CKP/CPH modes.
- Frame length is a parameter, so the same block drives a single slave (8 bits) or a daisy chain of slaves (16/24 bits).

Parameters:
- DATA_W, 8: frame length in bits; width of data_in and data_out.
- HALF_PERIOD, 2: clk cycles per SCK half period (SCK = clk / (2*HALF_PERIOD)); legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- CKP  in  1  SCK idle polarity; sampled at frame start.
- CPH  in  1  SCK phase; 0 = sample on leading edge, 1 = sample on trailing edge; sampled at frame start.
- start  in  1  request one frame; honoured only when busy=0.
- data_in  in  DATA_W  word to send; latched on the accepting edge.
- MISO  in  1  serial data from the slave(s).
- SCK  out  1  serial clock.
- SS  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave(s).
- data_out  out  DATA_W  last received word; held until the next frame completes.
- busy  out  1  high from frame acceptance until done.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (asynchronous, active-high rst):
  - Takes effect immediately, including mid-frame.
  - Output values: SS=1, SCK=CKP, MOSI=0, busy=0, done=0, data_out=0, state IDLE.
  - Internal counters and shift registers are cleared.
- State machine states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - SS=1 and SCK=CKP (follows CKP combinationally).
  - start=1 at edge T0: latch data_in, CKP and CPH. At T0, SS goes to 0, busy goes to 1, and the state moves to SETUP.
- SETUP:
  - Lasts HALF_PERIOD cycles; SCK stays idle.
  - CPH=0: MOSI presents bit 0 at T0.
- SHIFT:
  - SCK toggles every HALF_PERIOD cycles, 2*DATA_W toggles in total.
  - First toggle at T0+HALF_PERIOD; last toggle at T0+2*DATA_W*HALF_PERIOD, which returns SCK to idle.
  - Leading edge = first edge away from the idle level; trailing edge = the return to idle.
  - CPH=0:
    - MISO is sampled on each leading edge.
    - MOSI advances to the next bit on each trailing edge except the last.
  - CPH=1:
    - MOSI updates to the next bit on each leading edge; bit 0 on the first leading edge.
    - MISO is sampled on each trailing edge.
- Bit order: LSB first on both MOSI and MISO. The received bit is shifted into the MSB: rx = {MISO, rx[DATA_W-1:1]}.
- HOLD:
  - HALF_PERIOD cycles with SCK idle and SS still 0.
- DONE (edge T0+(2*DATA_W+2)*HALF_PERIOD):
  - SS=1, busy=0, done=1 for exactly one cycle.
  - data_out is loaded with the rx register; MOSI=0.
  - Next edge returns to IDLE.
  - The earliest next acceptance is the edge after done, which guarantees at least one cycle with SS high between frames.
- start while busy=1 or done=1 is ignored; no queueing.
- Changes to CKP/CPH during a frame are ignored; the latched values are used until the frame ends.
- data_in changes after acceptance do not affect the frame in progress.
- Frame latency from accepting edge to done is (2*DATA_W+2)*HALF_PERIOD cycles. Default: 36 cycles.

Optional Feature:
- Macro: TRANSMITTER_SPI_MSB_FIRST_EN.
- Defined:
  - MSB first on both lines; MOSI sends bit DATA_W-1 first.
  - Received bits shift in at the LSB: rx = {rx[DATA_W-2:0], MISO}.
- Undefined: LSB-first behaviour as above; this is the default and matches the slave receivers.

Test Plan:
- Loopback: MOSI tied to MISO, mode 00, data_in=0xA5, start at T0.
  - Exactly 8 SCK rising edges; SCK idles 0; SS low T0..T0+35.
  - done at T0+36 only; data_out=0xA5; busy falls with done.
- Mode 00, data_in=0x01: sample MOSI on each SCK rising edge -> sequence 1,0,0,0,0,0,0,0.
  - With the macro defined: 0,0,0,0,0,0,0,1.
- Mode 11 against a slave model returning 0x3C LSB first:
  - SCK idles 1; MISO sampled on rising (trailing) edges.
  - data_out=0x3C; SS high again at done.
- start held high through a whole frame, with data_in switched 0x11->0x22 mid-frame:
  - First frame sends 0x11.
  - A second frame is accepted on the edge after done and sends 0x22.
  - No extra frame is accepted while busy=1.
- rst pulsed after the 3rd SCK leading edge:
  - SS=1, SCK=CKP, busy=0, done=0 immediately without waiting for clk; data_out=0.
  - A following 0x5A loopback frame completes correctly.
- DATA_W=24, HALF_PERIOD=1, loopback, data_in=0xC0FFEE:
  - 24 SCK pulses; done at T0+50; data_out=0xC0FFEE.

Source files
------------

// File: rtl/transmitter_spi_if.sv
// Parallel-side and serial-side signals of the SPI master.
// The master modport is the transmitter's own view; slave is the view of whoever drives it.
interface transmitter_spi_if #(
  parameter int DATA_W = 8
) ();
  logic              CKP;
  logic              CPH;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              MISO;
  logic              SCK;
  logic              SS;
  logic              MOSI;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport master (
    input  CKP, CPH, start, data_in, MISO,
    output SCK, SS, MOSI, data_out, busy, done
  );

  modport slave (
    output CKP, CPH, start, data_in, MISO,
    input  SCK, SS, MOSI, data_out, busy, done
  );
endinterface

// File: rtl/transmitter_spi.sv
// Full-duplex SPI master, one DATA_W-bit frame per start, all four CKP/CPH modes.
// Define TRANSMITTER_SPI_MSB_FIRST_EN for MSB-first framing (default is LSB first).
module transmitter_spi #(
  parameter int DATA_W      = 8,
  parameter int HALF_PERIOD = 2
) (
  input logic               clk,
  input logic               rst,
  transmitter_spi_if.master bus
);
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int HW = $clog2(2 * DATA_W + 3);
  localparam logic [PW-1:0] PH_LAST     = PW'(HALF_PERIOD - 1);
  localparam logic [HW-1:0] H_LAST_TGL  = HW'(2 * DATA_W);
  localparam logic [HW-1:0] H_END_SHIFT = HW'(2 * DATA_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     ph_cnt;
  logic [HW-1:0]     h_cnt;
  logic [HW-1:0]     h_nx;
  logic              tick, toggle, lead, trail, accept, finish;
  logic              ckp_l, cph_l, sck_lvl, ss, mosi, busy, done;
  logic [DATA_W-1:0] tx, rx, data_out;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
`ifdef TRANSMITTER_SPI_MSB_FIRST_EN
    return w[DATA_W-1];
`else
    return w[0];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
`ifdef TRANSMITTER_SPI_MSB_FIRST_EN
    return w << 1;
`else
    return w >> 1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
`ifdef TRANSMITTER_SPI_MSB_FIRST_EN
    return {w[DATA_W-2:0], b};
`else
    return {b, w[DATA_W-1:1]};
`endif
  endfunction

  // h_cnt counts completed SCK half periods since acceptance; edge events key off h_nx.
  always_comb begin
    state_nx = state;
    tick     = (ph_cnt == PH_LAST);
    h_nx     = h_cnt + HW'(1);
    accept   = (state == IDLE) && bus.start;
    toggle   = ((state == SETUP) || (state == SHIFT)) && tick && (h_nx <= H_LAST_TGL);
    lead     = toggle && h_nx[0];
    trail    = toggle && !h_nx[0];
    finish   = (state == HOLD) && tick;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   if (tick) state_nx = SHIFT;
      SHIFT:   if (tick && (h_nx == H_END_SHIFT)) state_nx = HOLD;
      HOLD:    if (tick) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_cnt <= '0;
      h_cnt  <= '0;
    end else if ((state == SETUP) || (state == SHIFT) || (state == HOLD)) begin
      if (tick) begin
        ph_cnt <= '0;
        h_cnt  <= h_nx;
      end else begin
        ph_cnt <= ph_cnt + PW'(1);
      end
    end else begin
      ph_cnt <= '0;
      h_cnt  <= '0;
    end
  end

  // Mode and word are latched at acceptance so mid-frame input changes cannot disturb the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ckp_l    <= 1'b0;
      cph_l    <= 1'b0;
      sck_lvl  <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx       <= '0;
      rx       <= '0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ckp_l   <= bus.CKP;
        cph_l   <= bus.CPH;
        sck_lvl <= 1'b0;
        ss      <= 1'b0;
        busy    <= 1'b1;
        rx      <= '0;
        if (bus.CPH) begin
          tx   <= bus.data_in;
          mosi <= 1'b0;
        end else begin
          tx   <= tx_shift(bus.data_in);
          mosi <= out_bit(bus.data_in);
        end
      end else begin
        if (toggle) sck_lvl <= ~sck_lvl;
        if (lead) begin
          if (cph_l) begin
            mosi <= out_bit(tx);
            tx   <= tx_shift(tx);
          end else begin
            rx <= rx_shift(rx, bus.MISO);
          end
        end
        if (trail) begin
          if (cph_l) begin
            rx <= rx_shift(rx, bus.MISO);
          end else if (h_nx != H_LAST_TGL) begin
            mosi <= out_bit(tx);
            tx   <= tx_shift(tx);
          end
        end
        if (finish) begin
          ss       <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
          mosi     <= 1'b0;
          data_out <= rx;
        end
      end
    end
  end

  // In IDLE the clock idle level tracks CKP live; during a frame the latched polarity is used.
  assign bus.SCK      = (state == IDLE) ? bus.CKP : (ckp_l ^ sck_lvl);
  assign bus.SS       = ss;
  assign bus.MOSI     = mosi;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.data_out = data_out;
endmodule
